matrix_transpose_stream: RTL
============================

# matrix_transpose_stream

Parametrised, element-serial successor to the packed fixed-size transpose block. It accepts an R×C matrix of signed DATA_W-bit elements (Q20.12 at default width) as a row-major valid/ready stream and buffers it internally. It then emits either its transpose or an unchanged copy as a second valid/ready stream. It sits between the matrix producers and consumers in the fixed-point linear-algebra datapath, replacing the wide packed-bus interface with streaming handshakes.

## Interface
- DATA_W, 32, element width in bits (signed; Q20.12 at default)
- MAX_DIM, 6, maximum rows or cols; buffer holds MAX_DIM*MAX_DIM elements
- DIM_W, 3, width of rows/cols inputs; must satisfy 2^DIM_W > MAX_DIM

- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  begin a frame; sampled only in IDLE
- rows  in  DIM_W  row count R, latched with start
- cols  in  DIM_W  column count C, latched with start
- mode  in  1  0 = transpose, 1 = copy (row-major passthrough); latched with start
- in_valid  in  1  input element valid
- in_ready  out  1  block accepts input element
- in_data  in  DATA_W  input element, row-major order
- out_valid  out  1  output element valid
- out_ready  in  1  downstream accepts output element
- out_data  out  DATA_W  output element
- out_last  out  1  marks final output element of frame
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse after the final output handshake
- err  out  1  one-cycle pulse on rejected start (only with MTX_TRANSPOSE_DIMCHK_EN)

## Operation
- States: IDLE, LOAD, DRAIN, DONE.
- IDLE: in_ready=0, out_valid=0. When start=1, the block latches rows, cols and mode, clears its counters, and moves to LOAD. start is ignored in every other state.
- LOAD: in_ready=1.
  - Each handshake (in_valid&&in_ready) writes buf[r*MAX_DIM+c]. c increments; when c reaches C-1 it wraps to 0 and r increments.
  - The handshake on element R*C-1 moves the block to DRAIN and resets the counters.
- DRAIN: out_valid=1 and in_ready=0.
  - Transpose mode: outer loop c=0..C-1, inner loop r=0..R-1, out_data=buf[r*MAX_DIM+c].
  - Copy mode: outer loop r, inner loop c, same address formula.
  - Counters advance only on out_valid&&out_ready.
  - out_last=1 on the final element. Its handshake moves the block to DONE.
- DONE: done=1 for exactly one cycle, then IDLE.
- Element counts use width 2*DIM_W. No arithmetic is performed on data; bits pass through unchanged.
- Reset mid-operation returns the block to IDLE and discards the frame. Buffer contents are not cleared and are don't-care.
- Reset value of every output is 0: in_ready, out_valid, out_data, out_last, busy, done, err.

## Timing
- start is accepted in cycle N. in_ready is high from cycle N+1.
- After the last input handshake in cycle M, out_valid is high in cycle M+1 with the first output element. The buffer read is indexed by registered counters; no combinational path exists from in_* to out_*.
- Throughput is one element per cycle in each phase. An unstalled R×C frame occupies 2·R·C+2 cycles from start to done.
- While out_valid=1 and out_ready=0, out_data and out_last hold stable.
- A start seen in the same cycle as done is ignored. The next start is accepted from the IDLE cycle onward.

## Configuration
- MTX_TRANSPOSE_DIMCHK_EN defined:
  - The err port exists.
  - A start with rows=0, cols=0, rows>MAX_DIM or cols>MAX_DIM is rejected: err=1 for one cycle and the block stays in IDLE.
- Not defined:
  - The err port is absent.
  - rows and cols are clamped at latch time to the range [1, MAX_DIM]. A 0 becomes 1; a value above MAX_DIM becomes MAX_DIM.

## Test plan
- Transpose 2×3: mode=0, inputs 1,2,3,4,5,6, out_ready=1 -> outputs 1,4,2,5,3,6; out_last only on 6; done one cycle after the handshake on 6; 14 cycles from start to done.
- Copy 6×6: mode=1, inputs 0..35 -> outputs 0..35 in order; busy high throughout.
- Backpressure: 3×3 transpose with out_ready toggling 1,0,0,1,... -> sequence 1,4,7,2,5,8,3,6,9 with no duplicates or losses; out_data stable during stalls.
- 1×1 frame and start held high during LOAD/DRAIN -> single element with out_last=1; no second frame starts until after done, when the block is back in IDLE.
- rst asserted after 4 of 9 inputs are loaded -> all outputs 0 next cycle; a new 2×2 frame then transposes correctly.
- Illegal rows=7, cols=0: with the macro -> err pulse, busy stays 0. Without the macro -> treated as 6×1; six inputs are echoed in order.

Source files
------------

// File: rtl/matrix_transpose_stream_if.sv
// Element streams of matrix_transpose_stream: row-major input and transposed/copied output.
// The slave modport is the transpose block's view; master is the producer/consumer side.
interface matrix_transpose_stream_if #(
  parameter int DATA_W = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_last;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/matrix_transpose_stream.sv
// Buffers an R x C row-major element stream, then replays it transposed or unchanged.
// Define MTX_TRANSPOSE_DIMCHK_EN to reject bad dimensions with err instead of clamping them.
//
// state   | meaning
// S_IDLE  | waiting for start; rows/cols/mode latched on start
// S_LOAD  | accepting R*C elements into the buffer
// S_DRAIN | emitting R*C elements, column-major (transpose) or row-major (copy)
// S_DONE  | one-cycle done pulse, then back to S_IDLE
module matrix_transpose_stream #(
  parameter int DATA_W  = 32,
  parameter int MAX_DIM = 6,
  parameter int DIM_W   = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [DIM_W-1:0] rows,
  input  logic [DIM_W-1:0] cols,
  input  logic             mode,
  matrix_transpose_stream_if.slave strm,
  output logic             busy,
  output logic             done
`ifdef MTX_TRANSPOSE_DIMCHK_EN
  ,
  output logic             err
`endif
);
  localparam int AW = 2 * DIM_W;
  localparam logic [DIM_W-1:0] DIM_MAX = DIM_W'(MAX_DIM);
  localparam logic [DIM_W-1:0] DIM_ONE = DIM_W'(1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]        state;
  logic [DIM_W-1:0]  r_cnt, c_cnt;
  logic [DIM_W-1:0]  rows_q, cols_q;
  logic              mode_q;
  logic [AW-1:0]     addr;
  logic [DATA_W-1:0] mem [MAX_DIM*MAX_DIM];
  logic              in_fire, out_fire, r_end, c_end;
  logic [DIM_W-1:0]  rows_lat, cols_lat;
  logic              dim_bad;
  logic              err_q;

  // Same address formula in both phases; only the loop order differs in DRAIN.
  assign addr     = AW'(r_cnt) * AW'(MAX_DIM) + AW'(c_cnt);
  assign r_end    = (r_cnt == rows_q - DIM_ONE);
  assign c_end    = (c_cnt == cols_q - DIM_ONE);
  assign in_fire  = strm.in_valid && (state == S_LOAD);
  assign out_fire = strm.out_ready && (state == S_DRAIN);

  assign strm.in_ready  = (state == S_LOAD);
  assign strm.out_valid = (state == S_DRAIN);
  assign strm.out_data  = (state == S_DRAIN) ? mem[addr] : '0;
  assign strm.out_last  = (state == S_DRAIN) && r_end && c_end;
  assign busy           = (state != S_IDLE);
  assign done           = (state == S_DONE);

  always_comb begin
    rows_lat = rows;
    cols_lat = cols;
    dim_bad  = 1'b0;
`ifdef MTX_TRANSPOSE_DIMCHK_EN
    dim_bad = (rows == '0) || (cols == '0) || (rows > DIM_MAX) || (cols > DIM_MAX);
`else
    if (rows == '0)         rows_lat = DIM_ONE;
    else if (rows > DIM_MAX) rows_lat = DIM_MAX;
    if (cols == '0)         cols_lat = DIM_ONE;
    else if (cols > DIM_MAX) cols_lat = DIM_MAX;
`endif
  end

`ifdef MTX_TRANSPOSE_DIMCHK_EN
  assign err = err_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      r_cnt  <= '0;
      c_cnt  <= '0;
      rows_q <= DIM_ONE;
      cols_q <= DIM_ONE;
      mode_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state)
        S_IDLE: begin
          r_cnt <= '0;
          c_cnt <= '0;
          if (start) begin
            if (dim_bad) begin
              err_q <= 1'b1;
            end else begin
              rows_q <= rows_lat;
              cols_q <= cols_lat;
              mode_q <= mode;
              state  <= S_LOAD;
            end
          end
        end
        S_LOAD: begin
          if (in_fire) begin
            if (c_end) begin
              c_cnt <= '0;
              if (r_end) begin
                r_cnt <= '0;
                state <= S_DRAIN;
              end else begin
                r_cnt <= r_cnt + DIM_ONE;
              end
            end else begin
              c_cnt <= c_cnt + DIM_ONE;
            end
          end
        end
        S_DRAIN: begin
          if (out_fire) begin
            if (mode_q) begin
              if (c_end) begin
                c_cnt <= '0;
                if (r_end) begin
                  r_cnt <= '0;
                  state <= S_DONE;
                end else begin
                  r_cnt <= r_cnt + DIM_ONE;
                end
              end else begin
                c_cnt <= c_cnt + DIM_ONE;
              end
            end else begin
              if (r_end) begin
                r_cnt <= '0;
                if (c_end) begin
                  c_cnt <= '0;
                  state <= S_DONE;
                end else begin
                  c_cnt <= c_cnt + DIM_ONE;
                end
              end else begin
                r_cnt <= r_cnt + DIM_ONE;
              end
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Buffer is not reset; its contents are meaningless until a frame has loaded.
  always_ff @(posedge clk) begin
    if (in_fire) mem[addr] <= strm.in_data;
  end

endmodule
